// File: rtl/fifo_rd_ctrl_if.sv
// Read-side port bundle of the async FIFO. The controller connects through the slave
// modport; the environment driving read requests uses the master modport.
interface fifo_rd_ctrl_if #(
   parameter int AW = 4
);
   logic          i_rd_en;
   logic [AW:0]   i_rd_wr_ptr;
   logic [AW:0]   i_rd_ae_lvl;
   logic          i_rd_uf_clr;
   logic [AW-1:0] o_rd_addr;
   logic [AW:0]   o_rd_ptr;
   logic          o_rd_empty;
   logic          o_rd_aempty;
   logic [AW:0]   o_rd_level;
   logic          o_rd_valid;
   logic          o_rd_underflow;

   modport slave (
      input  i_rd_en, i_rd_wr_ptr, i_rd_ae_lvl, i_rd_uf_clr,
      output o_rd_addr, o_rd_ptr, o_rd_empty, o_rd_aempty, o_rd_level,
             o_rd_valid, o_rd_underflow
   );

   modport master (
      output i_rd_en, i_rd_wr_ptr, i_rd_ae_lvl, i_rd_uf_clr,
      input  o_rd_addr, o_rd_ptr, o_rd_empty, o_rd_aempty, o_rd_level,
             o_rd_valid, o_rd_underflow
   );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the async FIFO: synchronizes the Gray write
// pointer, advances the read pointer and produces empty/almost-empty/level/underflow.
module fifo_rd_ctrl #(
   parameter int AW          = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic             i_rd_clk,
   input logic             i_rd_rst,
   fifo_rd_ctrl_if.slave   rd_if
);

   // Handshake: a read is accepted when i_rd_en is high and the registered empty flag
   // is low; the RAM word for the accepted address is valid (o_rd_valid) one cycle later.

   logic [SYNC_STAGES-1:0][AW:0] r_sync;
   logic [AW:0]                  r_bin;
   logic [AW:0]                  r_gray;
   logic                         r_empty;
   logic                         r_aempty;
   logic [AW:0]                  r_level;
   logic                         r_valid;
   logic                         r_underflow;

   logic [AW:0] w_wq;
   logic [AW:0] w_wbin;
   logic        w_acc;
   logic [AW:0] w_bin_next;
   logic [AW:0] w_gray_next;
   logic [AW:0] w_lvl_next;

   assign w_wq        = r_sync[SYNC_STAGES-1];
   assign w_acc       = rd_if.i_rd_en & ~r_empty;
   assign w_bin_next  = r_bin + {{AW{1'b0}}, w_acc};
   assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;
   assign w_lvl_next  = w_wbin - w_bin_next;

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_wbin = '0;
      for (int i = 0; i <= AW; i++) begin
         w_wbin[i] = ^(w_wq >> i);
      end
   end

   always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
      if (i_rd_rst) begin
         r_sync <= '0;
      end else begin
         r_sync[0] <= rd_if.i_rd_wr_ptr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
      if (i_rd_rst) begin
         r_bin       <= '0;
         r_gray      <= '0;
         r_empty     <= 1'b1;
         r_aempty    <= 1'b1;
         r_level     <= '0;
         r_valid     <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_bin       <= w_bin_next;
         r_gray      <= w_gray_next;
         r_empty     <= (w_gray_next == w_wq);
         r_aempty    <= (w_lvl_next <= rd_if.i_rd_ae_lvl);
         r_level     <= w_lvl_next;
         r_valid     <= w_acc;
         // A new underflow takes priority over a clear in the same cycle.
         r_underflow <= (rd_if.i_rd_en & r_empty) | (r_underflow & ~rd_if.i_rd_uf_clr);
      end
   end

   assign rd_if.o_rd_addr      = r_bin[AW-1:0];
   assign rd_if.o_rd_ptr       = r_gray;
   assign rd_if.o_rd_empty     = r_empty;
   assign rd_if.o_rd_aempty    = r_aempty;
   assign rd_if.o_rd_level     = r_level;
   assign rd_if.o_rd_valid     = r_valid;
   assign rd_if.o_rd_underflow = r_underflow;

endmodule
